// File: rtl/rd53_sar_adc10_ctrl.sv
// 10-bit SAR ADC sequencer: sample, ten MSB-first bit trials, then a one-cycle DONE.
// Define RD53_SAR_OVF_EN to make OVF flag a full-scale (10'h3FF) result; otherwise OVF stays 0.
module rd53_sar_adc10_ctrl #(
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RST_B,
  input  logic       START,
  input  logic       ABORT,
  input  logic       COMP,
  output logic       SAMPLE_EN,
  output logic [9:0] DAC_BIN,
  output logic       BUSY,
  output logic       DONE,
  output logic [9:0] ADC_OUT,
  output logic       OVF
);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, FINISH} state_e;

  localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLE_CYCLES - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  dac_q, dac_d;
  logic        sample_en_q, sample_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [9:0]  adc_q, adc_d;
  logic        ovf_q, ovf_d;

  logic [9:0]  trial_bit;
  logic [9:0]  decided;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    dac_d       = dac_q;
    sample_en_d = sample_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    adc_d       = adc_q;
    ovf_d       = ovf_q;

    // An unknown comparator level falls through to the else path, clearing the bit.
    trial_bit = 10'(1) << bit_q;
    if (COMP == 1'b1) begin
      decided = dac_q;
    end else begin
      decided = dac_q & ~trial_bit;
    end

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d     = SAMPLE;
          cnt_d       = 4'd0;
          dac_d       = 10'd0;
          sample_en_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      SAMPLE: begin
        if (ABORT) begin
          state_d     = IDLE;
          cnt_d       = 4'd0;
          dac_d       = 10'd0;
          sample_en_d = 1'b0;
          busy_d      = 1'b0;
        end else if (cnt_q == SAMPLE_LAST) begin
          state_d     = CONV;
          cnt_d       = 4'd0;
          bit_d       = 4'd9;
          dac_d       = 10'h200;
          sample_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CONV: begin
        if (ABORT) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          dac_d   = 10'd0;
          busy_d  = 1'b0;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d = 4'd0;
          if (bit_q == 4'd0) begin
            state_d = FINISH;
            dac_d   = 10'd0;
            adc_d   = decided;
            done_d  = 1'b1;
`ifdef RD53_SAR_OVF_EN
            ovf_d   = (decided == 10'h3FF);
`else
            ovf_d   = 1'b0;
`endif
          end else begin
            bit_d = bit_q - 4'd1;
            dac_d = decided | (10'(1) << (bit_q - 4'd1));
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        dac_d       = 10'd0;
        sample_en_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      bit_q       <= 4'd0;
      dac_q       <= 10'd0;
      sample_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      adc_q       <= 10'd0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      dac_q       <= dac_d;
      sample_en_q <= sample_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      adc_q       <= adc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign SAMPLE_EN = sample_en_q;
  assign DAC_BIN   = dac_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ADC_OUT   = adc_q;
  assign OVF       = ovf_q;

endmodule
